// File: rtl/mul_error_monitor.sv
// Exhaustive error sweep for an approximate multiplier: walks every operand pair,
// compares the DUT result with the exact product and keeps worst-case statistics.
module mul_error_monitor #(
  parameter int WIDTH_A = 2,
  parameter int OUT_W   = 2 * WIDTH_A,
  parameter int ET      = 8,
  parameter int DUT_LAT = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  output logic [2*WIDTH_A-1:0]   dut_in,
  input  logic [OUT_W-1:0]       dut_out,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [OUT_W-1:0]       max_err,
  output logic [2*WIDTH_A-1:0]   worst_vec,
  output logic [2*WIDTH_A:0]     err_count
);

  localparam int VW = 2 * WIDTH_A;
  localparam int CW = (DUT_LAT > 0) ? $clog2(DUT_LAT + 1) : 1;
  localparam logic [OUT_W:0] ET_V = ET[OUT_W:0];

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t         state, state_nx;
  logic [CW-1:0]  cnt, cnt_nx;
  logic [VW-1:0]  dut_in_nx, worst_nx;
  logic [OUT_W-1:0] max_nx;
  logic [VW:0]    errc_nx;

  logic [WIDTH_A-1:0] op_a, op_b;
  logic [OUT_W:0]     prod;
  logic signed [OUT_W:0] diff;
  logic [OUT_W-1:0]   err;

  // The difference can go negative, so it is formed one bit wider and signed.
  function automatic logic [OUT_W-1:0] abs_err(input logic signed [OUT_W:0] d);
    logic signed [OUT_W:0] mag;
    mag = (d < 0) ? -d : d;
    return mag[OUT_W-1:0];
  endfunction

  assign op_a = dut_in[WIDTH_A-1:0];
  assign op_b = dut_in[VW-1:WIDTH_A];
  assign prod = (OUT_W+1)'(op_a) * (OUT_W+1)'(op_b);
  assign diff = $signed({1'b0, dut_out}) - $signed(prod);
  assign err  = abs_err(diff);

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    dut_in_nx = dut_in;
    max_nx    = max_err;
    worst_nx  = worst_vec;
    errc_nx   = err_count;
    case (state)
      IDLE, DONE: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (start) begin
          dut_in_nx = '0;
          max_nx    = '0;
          worst_nx  = '0;
          errc_nx   = '0;
          cnt_nx    = CW'(DUT_LAT);
          state_nx  = (DUT_LAT == 0) ? SAMPLE : SETTLE;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - 1'b1;
          if (cnt == CW'(1)) state_nx = SAMPLE;
        end
      end
      SAMPLE: begin
        if (abort) begin
          state_nx = IDLE;
        end else begin
          if (err != '0) errc_nx = err_count + 1'b1;
          // Strict compare so ties keep the earliest vector.
          if (err > max_err) begin
            max_nx   = err;
            worst_nx = dut_in;
          end
          if (&dut_in) begin
            state_nx = DONE;
          end else begin
            dut_in_nx = dut_in + 1'b1;
            cnt_nx    = CW'(DUT_LAT);
            state_nx  = (DUT_LAT == 0) ? SAMPLE : SETTLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      dut_in    <= '0;
      max_err   <= '0;
      worst_vec <= '0;
      err_count <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      dut_in    <= dut_in_nx;
      max_err   <= max_nx;
      worst_vec <= worst_nx;
      err_count <= errc_nx;
    end
  end

  assign busy = (state == SETTLE) || (state == SAMPLE);
  assign done = (state == DONE);
  assign pass = done && ({1'b0, max_err} <= ET_V);

endmodule

// File: tb/tb_mul_error_monitor.sv
// Scoreboard bench: two monitor instances (combinational and 2-cycle-latency DUT
// models) driven by directed sweeps; a per-instance monitor checks each finished sweep.
module tb_mul_error_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_s [2];
  logic       abort_s [2];
  logic [3:0] din_s   [2];
  logic [3:0] dout_s  [2];
  logic       busy_s  [2];
  logic       done_s  [2];
  logic       pass_s  [2];
  logic [3:0] maxe_s  [2];
  logic [3:0] worst_s [2];
  logic [4:0] errc_s  [2];

  int n_checks = 0;
  int n_fail   = 0;
  int mode     = 0;  // instance 0 DUT model: 0 exact, 1 const 7, 2 stuck-at-0, 3 pipelined

  typedef struct {
    logic [3:0] max_err;
    logic [3:0] worst;
    logic [4:0] errc;
    logic       done;
    logic       pass;
    int         cycles;
    bit         errc_nz;
  } exp_t;

  exp_t exp_q[$];

  mul_error_monitor #(.WIDTH_A(2), .OUT_W(4), .ET(8), .DUT_LAT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .abort(abort_s[0]),
    .dut_in(din_s[0]), .dut_out(dout_s[0]), .busy(busy_s[0]), .done(done_s[0]),
    .pass(pass_s[0]), .max_err(maxe_s[0]), .worst_vec(worst_s[0]), .err_count(errc_s[0]));

  mul_error_monitor #(.WIDTH_A(2), .OUT_W(4), .ET(8), .DUT_LAT(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .abort(abort_s[1]),
    .dut_in(din_s[1]), .dut_out(dout_s[1]), .busy(busy_s[1]), .done(done_s[1]),
    .pass(pass_s[1]), .max_err(maxe_s[1]), .worst_vec(worst_s[1]), .err_count(errc_s[1]));

  function automatic logic [3:0] prod4(input logic [3:0] v);
    return {2'b00, v[1:0]} * {2'b00, v[3:2]};
  endfunction

  logic [3:0] p1_0, p2_0, p1_1, p2_1;
  always @(posedge clk) begin
    p1_0 <= prod4(din_s[0]);
    p2_0 <= p1_0;
    p1_1 <= prod4(din_s[1]);
    p2_1 <= p1_1;
  end

  always_comb begin
    dout_s[0] = p2_0;
    case (mode)
      0: dout_s[0] = prod4(din_s[0]);
      1: dout_s[0] = 4'd7;
      2: dout_s[0] = 4'd0;
      default: dout_s[0] = p2_0;
    endcase
  end
  assign dout_s[1] = p2_1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int mx, input int wv, input int ec, input bit dn,
                      input bit ps, input int cyc, input bit nz);
    exp_t e;
    e.max_err = 4'(mx); e.worst = 4'(wv); e.errc = 5'(ec);
    e.done = dn; e.pass = ps; e.cycles = cyc; e.errc_nz = nz;
    exp_q.push_back(e);
  endtask

  for (genvar g = 0; g < 2; g++) begin : mon
    localparam int LAT = (g == 0) ? 0 : 2;
    int cyc = 0;
    int run = 0;
    logic pb = 1'b0;
    logic [3:0] pin = 4'd0;
    exp_t e;
    always @(negedge clk) begin
      if (!rst_n) begin
        pb  = 1'b0;
        cyc = 0;
      end else begin
        if (busy_s[g] && !pb) begin
          cyc = 0;
          run = 0;
          pin = din_s[g];
          check("first_vector", int'(din_s[g]), 0);
          check("stats_cleared", int'(errc_s[g]), 0);
        end
        if (busy_s[g]) begin
          cyc++;
          if (din_s[g] != pin) begin
            check("vector_hold", run, LAT + 1);
            check("vector_step", int'(din_s[g]), int'(pin) + 1);
            run = 1;
            pin = din_s[g];
          end else begin
            run++;
          end
        end
        if (!busy_s[g] && pb) begin
          if (exp_q.size() == 0) begin
            check("unexpected_sweep_end", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("busy_cycles", cyc, e.cycles);
            check("done", int'(done_s[g]), int'(e.done));
            if (e.errc_nz) begin
              check("err_count_nonzero", int'(errc_s[g] != 5'd0), 1);
            end else begin
              check("max_err", int'(maxe_s[g]), int'(e.max_err));
              check("worst_vec", int'(worst_s[g]), int'(e.worst));
              check("err_count", int'(errc_s[g]), int'(e.errc));
              check("pass", int'(pass_s[g]), int'(e.pass));
            end
          end
        end
        pb = busy_s[g];
      end
    end
  end

  task automatic pulse_start(input int g);
    @(posedge clk); #1 start_s[g] = 1'b1;
    @(posedge clk); #1 start_s[g] = 1'b0;
  endtask

  task automatic pulse_abort(input int g);
    @(posedge clk); #1 abort_s[g] = 1'b1;
    @(posedge clk); #1 abort_s[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int budget);
    int k = 0;
    while (!done_s[g] && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("sweep_completes", int'(done_s[g]), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_dut_in"}, int'(din_s[0]), 0);
    check({tag, "_busy"}, int'(busy_s[0]), 0);
    check({tag, "_done"}, int'(done_s[0]), 0);
    check({tag, "_pass"}, int'(pass_s[0]), 0);
    check({tag, "_max_err"}, int'(maxe_s[0]), 0);
    check({tag, "_worst_vec"}, int'(worst_s[0]), 0);
    check({tag, "_err_count"}, int'(errc_s[0]), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0;
      abort_s[i] = 1'b0;
    end
    #12 check_zero("reset");
    @(negedge clk); rst_n = 1'b1;

    // Exact combinational multiplier.
    mode = 0;
    push(0, 0, 0, 1, 1, 16, 0);
    pulse_start(0);
    wait_done(0, 100);

    // Abort while idle-done clears done/pass only.
    pulse_abort(0);
    check("abort_idle_done", int'(done_s[0]), 0);
    check("abort_idle_pass", int'(pass_s[0]), 0);

    // Constant 7 output.
    mode = 1;
    push(7, 0, 16, 1, 1, 16, 0);
    pulse_start(0);
    wait_done(0, 100);

    // start together with abort in DONE: no sweep.
    @(posedge clk); #1 start_s[0] = 1'b1; abort_s[0] = 1'b1;
    @(posedge clk); #1 start_s[0] = 1'b0; abort_s[0] = 1'b0;
    check("start_abort_busy", int'(busy_s[0]), 0);
    check("start_abort_done", int'(done_s[0]), 0);
    @(negedge clk);
    check("start_abort_still_idle", int'(busy_s[0]), 0);

    // Stuck-at-zero output.
    mode = 2;
    push(9, 15, 9, 1, 0, 16, 0);
    pulse_start(0);
    wait_done(0, 100);

    // Two-stage pipelined exact DUT with matching latency.
    push(0, 0, 0, 1, 1, 48, 0);
    pulse_start(1);
    wait_done(1, 200);

    // Same pipelined DUT but latency 0: must see errors.
    mode = 3;
    push(0, 0, 0, 1, 0, 16, 1);
    pulse_start(0);
    wait_done(0, 100);

    // Abort during vector 5 with constant-7 DUT.
    mode = 1;
    push(7, 0, 5, 0, 0, 6, 0);
    pulse_start(0);
    k = 0;
    while (din_s[0] != 4'd5 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("reached_vector5", int'(din_s[0]), 5);
    abort_s[0] = 1'b1;
    @(posedge clk); #1 abort_s[0] = 1'b0;
    check("abort_busy", int'(busy_s[0]), 0);
    check("abort_done", int'(done_s[0]), 0);
    check("abort_pass", int'(pass_s[0]), 0);
    check("abort_frozen_count", int'(errc_s[0]), 5);
    repeat (2) @(negedge clk);

    // Restart after abort begins at vector 0 with fresh statistics.
    push(7, 0, 16, 1, 1, 16, 0);
    pulse_start(0);
    wait_done(0, 100);

    // Asynchronous reset mid-sweep.
    mode = 0;
    pulse_start(0);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Full sweep with a stray start during busy.
    push(0, 0, 0, 1, 1, 16, 0);
    pulse_start(0);
    repeat (4) @(posedge clk);
    #1 start_s[0] = 1'b1;
    @(posedge clk); #1 start_s[0] = 1'b0;
    wait_done(0, 100);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
